// File: rtl/sfp_norm_ctrl_if.sv
// sfp_norm_ctrl_if: handshake, memory and SFP control bundle of the
// normalization-row sequencer. The master side is the sequencer itself,
// the slave side is the surrounding core (start source, memories, SFP, peer).
interface sfp_norm_ctrl_if #(
  parameter int addr_bw = 4
);
  logic               start;
  logic               pass_mode;
  logic               busy;
  logic               done;
  logic               err;
  logic               pmem_rd;
  logic [addr_bw-1:0] pmem_addr;
  logic               acc;
  logic               div;
  logic               pass_through;
  logic               fifo_ext_rd;
  logic               sync_out;
  logic               sync_in;
  logic               sfp_valid;
  logic               omem_wr;
  logic [addr_bw-1:0] omem_addr;

  modport master (
    input  start, pass_mode, sync_in, sfp_valid,
    output busy, done, err, pmem_rd, pmem_addr, acc, div, pass_through,
           fifo_ext_rd, sync_out, omem_wr, omem_addr
  );

  modport slave (
    output start, pass_mode, sync_in, sfp_valid,
    input  busy, done, err, pmem_rd, pmem_addr, acc, div, pass_through,
           fifo_ext_rd, sync_out, omem_wr, omem_addr
  );
endinterface

// File: rtl/sfp_norm_ctrl.sv
// sfp_norm_ctrl: per-row sequencer for one core's SFP normalization row.
// Reads a psum row, accumulates it, exchanges the row sum with the peer core,
// divides, waits for the divider and writes the output row. Pass mode skips
// accumulate/divide and streams rows straight through (2 cycles per row).
// All outputs come straight from flops; they are decoded from the next state
// so that each output lines up with the state it belongs to.
module sfp_norm_ctrl #(
  parameter int num_rows   = 8,
  parameter int addr_bw    = 4,
  parameter int tmo_cycles = 64
) (
  input  logic            clk,
  input  logic            reset,
  sfp_norm_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(tmo_cycles + 1);

  localparam logic [addr_bw-1:0] LAST_ROW = addr_bw'(num_rows - 1);
  localparam logic [addr_bw-1:0] ROW_STEP = {{(addr_bw-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(tmo_cycles - 1);
  // stale-valid guard: WAIT cycles 0..2 ignore sfp_valid
  localparam logic [CNT_W-1:0]   GUARD    = CNT_W'(3);
  localparam logic [CNT_W-1:0]   CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RD   = 4'd1,
    ST_ACC1 = 4'd2,
    ST_ACC2 = 4'd3,
    ST_SYNC = 4'd4,
    ST_DIV  = 4'd5,
    ST_WAIT = 4'd6,
    ST_WB   = 4'd7,
    ST_DONE = 4'd8
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [addr_bw-1:0] row_r;
  logic [addr_bw-1:0] row_nxt_s;
  logic               mode_r;
  logic               mode_nxt_s;
  logic               err_r;
  logic               err_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;

  logic               busy_r;
  logic               done_r;
  logic               pmem_rd_r;
  logic               acc_r;
  logic               div_r;
  logic               pass_r;
  logic               sync_out_r;
  logic               omem_wr_r;

  // Next-state, row, mode and sticky-error decision for the row sequencer.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    mode_nxt_s  = mode_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RD;
          row_nxt_s   = '0;
          mode_nxt_s  = bus.pass_mode;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mode_r) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_ACC1;
        end
      end
      ST_ACC1: state_nxt_s = ST_ACC2;
      ST_ACC2: state_nxt_s = ST_SYNC;
      ST_SYNC: begin
        // both cores see the overlap in the same cycle and leave together
        if (sync_out_r && bus.sync_in) begin
          state_nxt_s = ST_DIV;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_DIV: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if ((cnt_r >= GUARD) && bus.sfp_valid) begin
          state_nxt_s = ST_WB;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WB: begin
        if (row_r == LAST_ROW) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RD;
          row_nxt_s   = row_r + ROW_STEP;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Dwell counter for SYNC/WAIT: zero on entry, counts while the state is held.
  always_comb begin
    cnt_nxt_s = '0;
    if ((state_nxt_s == state_r) && ((state_r == ST_SYNC) || (state_r == ST_WAIT))) begin
      cnt_nxt_s = cnt_r + CNT_STEP;
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Sequencer state and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      row_r      <= '0;
      mode_r     <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pmem_rd_r  <= 1'b0;
      acc_r      <= 1'b0;
      div_r      <= 1'b0;
      pass_r     <= 1'b0;
      sync_out_r <= 1'b0;
      omem_wr_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      row_r      <= row_nxt_s;
      mode_r     <= mode_nxt_s;
      err_r      <= err_nxt_s;
      cnt_r      <= cnt_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
      pmem_rd_r  <= (state_nxt_s == ST_RD);
      acc_r      <= (state_nxt_s == ST_ACC1) || (state_nxt_s == ST_ACC2);
      div_r      <= (state_nxt_s == ST_DIV);
      sync_out_r <= (state_nxt_s == ST_SYNC);
      omem_wr_r  <= (state_nxt_s == ST_WB);
      pass_r     <= (state_nxt_s != ST_IDLE) ? mode_nxt_s : 1'b0;
    end
  end

  // The row register is held from RD through WB, so it drives both addresses.
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
  assign bus.pmem_rd      = pmem_rd_r;
  assign bus.pmem_addr    = row_r;
  assign bus.acc          = acc_r;
  assign bus.div          = div_r;
  assign bus.pass_through = pass_r;
  assign bus.fifo_ext_rd  = 1'b0;
  assign bus.sync_out     = sync_out_r;
  assign bus.omem_wr      = omem_wr_r;
  assign bus.omem_addr    = row_r;

endmodule

// File: tb/tb_sfp_norm_ctrl.sv
// tb_sfp_norm_ctrl: builds, per run, a cycle schedule of stimulus and
// expected outputs from per-row durations (peer delay, divider latency,
// timeouts), then plays it against the DUT and compares every cycle.
module tb_sfp_norm_ctrl;

  localparam int NUM_ROWS = 8;
  localparam int ADDR_BW  = 4;
  localparam int TMO      = 64;

  // bit positions in the packed control vector
  localparam int B_BUSY = 9;
  localparam int B_DONE = 8;
  localparam int B_ERR  = 7;
  localparam int B_RD   = 6;
  localparam int B_ACC  = 5;
  localparam int B_DIV  = 4;
  localparam int B_PT   = 3;
  localparam int B_SO   = 2;
  localparam int B_WR   = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sfp_norm_ctrl_if #(.addr_bw(ADDR_BW)) bus ();

  sfp_norm_ctrl #(
    .num_rows  (NUM_ROWS),
    .addr_bw   (ADDR_BW),
    .tmo_cycles(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [9:0] ctl;
    int         row;
    bit         chk_addr;
    bit         start;
    bit         pm;
    bit         sync_in;
    bit         valid;
  } cyc_t;

  cyc_t     sched[$];
  int       n_checks = 0;
  int       n_errors = 0;
  int       cyc      = 0;
  bit       err_m    = 1'b0;
  int       row_m    = 0;
  int       p_arr[NUM_ROWS];
  int       w_arr[NUM_ROWS];
  bit [2:0] stale_arr[NUM_ROWS];
  int       mark_row = -1;
  int       mark_idx = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [9:0] obs_ctl();
    return {bus.busy, bus.done, bus.err, bus.pmem_rd, bus.acc, bus.div,
            bus.pass_through, bus.sync_out, bus.omem_wr, bus.fifo_ext_rd};
  endfunction

  // One cycle with default expectations; random start while busy must be ignored.
  function automatic cyc_t mk(input bit busy, input bit pt);
    cyc_t c;
    c.ctl         = '0;
    c.ctl[B_BUSY] = busy;
    c.ctl[B_ERR]  = err_m;
    c.ctl[B_PT]   = pt;
    c.row         = row_m;
    c.chk_addr    = busy;
    c.start       = busy ? ($urandom_range(0, 5) == 0) : 1'b0;
    c.pm          = 1'($urandom_range(0, 1));
    c.sync_in     = 1'($urandom_range(0, 1));
    c.valid       = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic rand_rows();
    for (int r = 0; r < NUM_ROWS; r++) begin
      p_arr[r]     = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 4);
      w_arr[r]     = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 6);
      stale_arr[r] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic set_rows(input int p, input int w, input bit [2:0] st);
    for (int r = 0; r < NUM_ROWS; r++) begin
      p_arr[r]     = p;
      w_arr[r]     = w;
      stale_arr[r] = st;
    end
  endtask

  // Reference schedule for one run: start cycle, rows, DONE, idle gap.
  task automatic gen_run(input bit mode, input bit done_start);
    cyc_t c;
    bit   abort;
    abort   = 1'b0;
    c       = mk(1'b0, 1'b0);
    c.start = 1'b1;
    c.pm    = mode;
    sched.push_back(c);
    err_m = 1'b0;
    row_m = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (abort) break;
      row_m = r;
      c = mk(1'b1, mode); c.ctl[B_RD] = 1'b1; sched.push_back(c);
      if (!mode) begin
        c = mk(1'b1, 1'b0); c.ctl[B_ACC] = 1'b1; sched.push_back(c);
        c = mk(1'b1, 1'b0); c.ctl[B_ACC] = 1'b1; sched.push_back(c);
        // peer raises sync_in p cycles after our sync_out rises
        for (int k = 0; k < TMO; k++) begin
          c = mk(1'b1, 1'b0);
          c.ctl[B_SO] = 1'b1;
          c.sync_in   = (k >= p_arr[r]);
          sched.push_back(c);
          if (k >= p_arr[r]) break;
          if (k == TMO - 1) abort = 1'b1;
        end
        if (!abort) begin
          c = mk(1'b1, 1'b0); c.ctl[B_DIV] = 1'b1; sched.push_back(c);
          for (int k = 0; k < TMO; k++) begin
            c = mk(1'b1, 1'b0);
            c.valid = (k < 3) ? stale_arr[r][k] : (k >= w_arr[r]);
            if ((r == mark_row) && (k == 0)) mark_idx = sched.size();
            sched.push_back(c);
            if ((k >= 3) && c.valid) break;
            if (k == TMO - 1) abort = 1'b1;
          end
        end
      end
      if (!abort) begin
        c = mk(1'b1, mode); c.ctl[B_WR] = 1'b1; sched.push_back(c);
      end
    end
    if (abort) err_m = 1'b1;
    c = mk(1'b1, mode);
    c.ctl[B_DONE] = 1'b1;
    c.chk_addr    = 1'b0;
    if (done_start) c.start = 1'b1;
    sched.push_back(c);
    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
      c = mk(1'b0, 1'b0);
      sched.push_back(c);
    end
  endtask

  // Play the schedule; optionally assert reset in cycle reset_at and stop there.
  task automatic exec_sched(input int reset_at);
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      #1;
      reset         = (i == reset_at);
      bus.start     = sched[i].start;
      bus.pass_mode = sched[i].pm;
      bus.sync_in   = sched[i].sync_in;
      bus.sfp_valid = sched[i].valid;
      @(negedge clk);
      check_val($sformatf("ctl c%0d", cyc), 32'(obs_ctl()), 32'(sched[i].ctl));
      if (sched[i].chk_addr) begin
        check_val($sformatf("pmem_addr c%0d", cyc), 32'(bus.pmem_addr), 32'(sched[i].row));
        check_val($sformatf("omem_addr c%0d", cyc), 32'(bus.omem_addr), 32'(sched[i].row));
      end
      cyc++;
      if (i == reset_at) break;
    end
    sched.delete();
    if (reset_at >= 0) begin
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.sync_in   = 1'b0;
      bus.sfp_valid = 1'b0;
      @(negedge clk);
      check_val("after_reset ctl", 32'(obs_ctl()), 32'd0);
      check_val("after_reset pmem_addr", 32'(bus.pmem_addr), 32'd0);
      check_val("after_reset omem_addr", 32'(bus.omem_addr), 32'd0);
      cyc++;
      err_m = 1'b0;
      row_m = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.pass_mode = 1'b0;
    bus.sync_in   = 1'b0;
    bus.sfp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("reset ctl", 32'(obs_ctl()), 32'd0);
    check_val("reset pmem_addr", 32'(bus.pmem_addr), 32'd0);
    check_val("reset omem_addr", 32'(bus.omem_addr), 32'd0);

    // pass mode stream, start also offered in the DONE cycle
    gen_run(1'b1, 1'b1);
    exec_sched(-1);

    // peer answers at once, stale valid in WAIT cycles 2 and 3
    set_rows(0, 1, 3'b110);
    gen_run(1'b0, 1'b1);
    exec_sched(-1);

    // late peer on every row
    set_rows(20, 3, 3'b000);
    gen_run(1'b0, 1'b0);
    exec_sched(-1);

    // divider never completes on row 0
    set_rows(0, 3, 3'b000);
    w_arr[0] = 1000;
    gen_run(1'b0, 1'b0);
    exec_sched(-1);

    // next run clears err; peer never shows up on row 2
    set_rows(1, 4, 3'b010);
    p_arr[2] = 100;
    gen_run(1'b0, 1'b1);
    exec_sched(-1);

    // reset in WAIT of row 3, then a fresh run from row 0
    set_rows(0, 10, 3'b000);
    mark_row = 3;
    gen_run(1'b0, 1'b0);
    mark_row = -1;
    exec_sched(mark_idx + 1);
    set_rows(0, 3, 3'b000);
    gen_run(1'b0, 1'b0);
    exec_sched(-1);

    for (int n = 0; n < 12; n++) begin
      rand_rows();
      gen_run(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      exec_sched(-1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sfp_norm_ctrl.md
# sfp_norm_ctrl

Sequencer for one core's SFP normalization row. Per output row it reads partial sums from psum memory, drives the SFP row's accumulate/divide controls, and synchronizes with the peer core so both exchange row sums before dividing. It waits for divider completion and issues the output-memory write. In pass mode it bypasses accumulate and divide and streams rows straight through.

## Interface
- num_rows, 8: rows processed per run.
- addr_bw, 4: width of the row address; must satisfy 2^addr_bw >= num_rows.
- tmo_cycles, 64: maximum cycles allowed in SYNC or WAIT before abort.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle run request; ignored while busy.
- pass_mode  in  1  sampled with start; 1 = bypass normalization.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- done  out  1  one-cycle pulse at run end, with or without error.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- pmem_rd  out  1  psum memory read enable; memory has 1-cycle read latency.
- pmem_addr  out  addr_bw  psum row address; held from RD through WB.
- acc  out  1  SFP accumulate enable.
- div  out  1  SFP divide request, one-cycle pulse.
- pass_through  out  1  SFP bypass; equals the latched mode while busy.
- fifo_ext_rd  out  1  tied to 0.
- sync_out  out  1  local sum ready for exchange (registered).
- sync_in  in  1  peer core's sync_out.
- sfp_valid  in  1  SFP divider-complete flag.
- omem_wr  out  1  output memory write enable.
- omem_addr  out  addr_bw  output row address, equal to the current row.

## Operation
- States: IDLE, RD, ACC1, ACC2, SYNC, DIV, WAIT, WB, DONE.
- IDLE: start=1 latches pass_mode, clears err, sets row=0, and moves to RD.
- RD: pmem_rd=1, pmem_addr=row. Next state is ACC1, or WB if pass mode.
- ACC1 and ACC2: acc=1 in each. ACC1 captures the per-half sums and ACC2 commits the total to the SFP sum register. After ACC2, go to SYNC.
- SYNC: sync_out=1.
  - Leave for DIV in the first cycle where sync_out=1 and sync_in=1. sync_out deasserts in the next cycle.
  - Both cores see the overlap in the same cycle, so both leave together.
- DIV: div=1 for exactly one cycle, then WAIT.
- WAIT:
  - sfp_valid is ignored for the first 3 WAIT cycles (guard against a stale valid from the previous row).
  - From the 4th cycle on, sfp_valid=1 moves to WB.
- WB:
  - omem_wr=1, omem_addr=row.
  - If row==num_rows-1, go to DONE. Otherwise increment row and go to RD.
- DONE: done=1 for one cycle, then IDLE.
- Timeout:
  - A cycle counter is cleared on entry to SYNC and on entry to WAIT.
  - If it reaches tmo_cycles while still in that state: set err, deassert sync_out, skip the remaining rows, go to DONE.
  - No omem_wr is issued for the aborted row.
- pmem_addr stays constant from RD through WB. The SFP samples its inputs every cycle, so memory output must stay stable during the divide.
- Row counter width is addr_bw. It never wraps within a run.

## Timing
- Reset values: all outputs 0; state IDLE; row 0; err 0.
- Reset asserted mid-run returns to IDLE on the next edge with no done pulse.
- start arrives in cycle T:
  - busy=1 and RD in T+1.
  - Normal mode: ACC1 at T+2, ACC2 at T+3, SYNC earliest at T+4, DIV earliest at T+5.
  - Pass mode: WB at T+2, so one row takes 2 cycles.
- Minimum normal row: RD, ACC1, ACC2, SYNC(1), DIV, WAIT(4), WB = 10 cycles.
- done and busy are both high in the DONE cycle; busy is 0 in the following cycle.
- start is ignored in the DONE cycle. An accepted start needs state IDLE.
- sync_in is used directly and is treated as synchronous (same clock domain as the peer core).

## Test plan
- Pass mode, num_rows=8, start at cycle 0:
  - pmem_rd at cycles 1,3,…,15; omem_wr at cycles 2,4,…,16 with addr 0..7.
  - done at cycle 17; acc, div and sync_out never assert.
- Normal mode, one row, sync_in tied to the DUT's own sync_out, sfp_valid high from the 2nd WAIT cycle:
  - acc at cycles 2–3, sync_out at 4, div at 5, WB at 10.
  - Stale valid is rejected until the 4th WAIT cycle.
- Peer late: sync_in rises 20 cycles after sync_out.
  - DIV occurs the cycle after the overlap; sync_out falls the same cycle; no err.
- Timeout: sfp_valid held 0.
  - err=1 after 64 WAIT cycles, done pulses, no omem_wr for that row, busy drops.
  - The next start clears err.
- Reset mid-run (in WAIT at row 3): all outputs 0 next cycle, no done pulse.
  - A new start restarts at row 0.
- start asserted while busy and in the DONE cycle: ignored; exactly one run and one done pulse.
